ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL provide parameter AW, default 8, meaning PC/instruction-address width in bits.
REQ-002 SHALL provide parameter IW, default 16, meaning instruction word width, equal to the decoder opcode input width.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port im_req  output  1  instruction-memory read request.
REQ-006 SHALL have port im_addr  output  AW  instruction-memory read address.
REQ-007 SHALL have port im_ack  input  1  memory read completion; im_rdata is valid in the same cycle.
REQ-008 SHALL have port im_rdata  input  IW  instruction word returned by memory.
REQ-009 SHALL have port o  output  IW  instruction presented to the decoder.
REQ-010 SHALL have port ov  output  1  o and opc are valid.
REQ-011 SHALL have port ordy  input  1  decoder consumes o this cycle.
REQ-012 SHALL have port opc  output  AW  address of the instruction on o, used for PC-relative branches.
REQ-013 SHALL have port pcwe  input  1  branch taken; redirect fetch.
REQ-014 SHALL have port npc  input  AW  redirect target, sampled when pcwe=1.
REQ-015 SHALL have port h  input  1  halt decoded.
REQ-016 SHALL have port halted  output  1  fetch permanently stopped.

Function
REQ-017 SHALL keep a fetch pointer fpc, a 2-entry FIFO of {addr, word}, a 1-bit outstanding flag (busy), and a 1-bit discard flag (drop).
REQ-018 SHALL assert im_req when busy=1, or when (halted=0 and pcwe=0 and FIFO count + busy < 2); im_addr SHALL equal fpc.
REQ-019 SHALL hold im_req=1 and im_addr stable from issue until the cycle of im_ack; at most one request outstanding.
REQ-020 On im_ack with drop=0 and pcwe=0, SHALL push {fpc, im_rdata} into the FIFO and set fpc <= fpc+1, modulo 2^AW (0xFF wraps to 0x00).
REQ-021 On im_ack with drop=1, SHALL discard im_rdata, clear drop, and leave fpc unchanged.
REQ-022 A new request MAY issue in the cycle after im_ack; 1-cycle-ack memory SHALL sustain 1 instruction per 2 cycles minimum, with the FIFO absorbing consumer stalls.
REQ-023 SHALL drive ov=1 when the FIFO is non-empty and halted=0; o/opc SHALL show the FIFO head; pop SHALL occur when ov and ordy are both 1.
REQ-024 When ov=0, SHALL drive o=0 (NOP encoding) and opc=0.
REQ-025 On pcwe=1, SHALL flush the FIFO and set fpc <= npc; if busy=1 and im_ack=0, SHALL set drop=1.
REQ-026 If pcwe=1 coincides with im_ack, SHALL discard im_rdata without setting drop.
REQ-027 If pcwe=1 coincides with a pop, the redirect SHALL win, leaving the FIFO empty.
REQ-028 SHALL raise no im_req in the pcwe cycle; fetch from npc SHALL begin the following cycle, or after the dropped ack.
REQ-029 On h=1 with ov=1 and ordy=1, SHALL set halted=1, which is sticky until reset.
REQ-030 While halted=1, SHALL issue no new requests and SHALL discard any outstanding ack.
REQ-031 If h and pcwe coincide, SHALL set halted and SHALL still load fpc <= npc.
REQ-032 A push and a pop in the same cycle SHALL keep the count unchanged.
REQ-033 SHALL never push while the FIFO is full; REQ-018 guarantees this.

Reset
REQ-034 While rst=1, SHALL force fpc=0, FIFO empty, busy=0, drop=0, halted=0, im_req=0, im_addr=0, ov=0, o=0, and opc=0, immediately and without waiting for clk.
REQ-035 Reset asserted mid-request SHALL abandon the request; after release, the first request SHALL be to address 0x00.

Verification
REQ-036 Reset release, memory acks in 1 cycle returning word=addr+0x1000, ordy=1 -> o sequence 0x1000, 0x1001, 0x1002 with opc 0, 1, 2 and no gaps beyond REQ-022.
REQ-037 ordy=0 for 10 cycles -> exactly 2 entries buffered, im_req stays 0, ov=1 and o stable; on ordy=1, pops resume in order.
REQ-038 pcwe=1, npc=0x40 while a request to 0x05 is outstanding with a 3-cycle ack -> 0x05 data never appears on o; next im_addr=0x40; first o after redirect has opc=0x40.
REQ-039 pcwe coincident with im_ack and pop -> FIFO empty, ov=0 next cycle, next im_addr=npc.
REQ-040 fpc=0xFF fetch -> next im_addr=0x00.
REQ-041 h=1 consumed at opc=0x07 -> halted=1, ov=0 and im_req=0 thereafter; rst pulse restarts fetch at 0x00.

Source files
------------

// File: rtl/ifetch.sv
`default_nettype none
// ifetch -- instruction fetch unit: single-outstanding memory reads, 2-entry prefetch FIFO, redirect and halt
// Revision: 1.0
module ifetch #(
    parameter int AW = 8,
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic          im_req,
    output logic [AW-1:0] im_addr,
    input  logic          im_ack,
    input  logic [IW-1:0] im_rdata,
    output logic [IW-1:0] o,
    output logic          ov,
    input  logic          ordy,
    output logic [AW-1:0] opc,
    input  logic          pcwe,
    input  logic [AW-1:0] npc,
    input  logic          h,
    output logic          halted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DROP = 2'd2
    } mstate_e;

    mstate_e       state_q, state_d;
    logic [AW-1:0] fpc_q, fpc_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          halted_q, halted_d;

    logic [AW-1:0] addr_q [2];
    logic [IW-1:0] word_q [2];

    logic busy;
    logic issue;
    logic ack;
    logic pop;
    logic push;
    logic wr_idx;

    assign busy = (state_q != S_IDLE);

    // An outstanding request is held until its ack; a new one needs a free FIFO slot
    assign im_req  = !rst && (busy || (!halted_q && !pcwe && ((cnt_q + {1'b0, busy}) < 2'd2)));
    assign im_addr = fpc_q;

    assign issue  = im_req && !busy;
    assign ack    = im_ack && busy;
    assign ov     = (cnt_q != 2'd0) && !halted_q;
    assign pop    = ov && ordy;
    assign push   = ack && (state_q == S_BUSY) && !pcwe && !halted_q;
    assign wr_idx = rd_ptr_q ^ cnt_q[0];

    assign o      = ov ? word_q[rd_ptr_q] : '0;
    assign opc    = ov ? addr_q[rd_ptr_q] : '0;
    assign halted = halted_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (issue) state_d = S_BUSY;
            S_BUSY: begin
                if (ack) begin
                    state_d = S_IDLE;
                end else if (pcwe) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: if (ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A redirect flushes the FIFO and overrides any simultaneous push or pop
    always_comb begin
        fpc_d    = fpc_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        halted_d = halted_q | (h & pop);
        if (pcwe) begin
            fpc_d = npc;
            cnt_d = 2'd0;
        end else begin
            if (push) begin
                fpc_d = fpc_q + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q    <= '0;
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            fpc_q    <= fpc_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_idx] <= fpc_q;
            word_q[wr_idx] <= im_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// tb_ifetch -- randomized bench for ifetch against a queue-based fetch model and a latency-configurable memory
// Revision: 1.0
module tb_ifetch;
    localparam int AW = 8;
    localparam int IW = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [IW-1:0] w;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          im_req;
    logic [AW-1:0] im_addr;
    logic          im_ack;
    logic [IW-1:0] im_rdata;
    logic [IW-1:0] o;
    logic          ov;
    logic          ordy;
    logic [AW-1:0] opc;
    logic          pcwe;
    logic [AW-1:0] npc;
    logic          h;
    logic          halted;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model
    bit            mem_busy;
    logic [AW-1:0] mem_addr;
    int            mem_wait;
    int            lat_min = 1;
    int            lat_max = 1;
    int            n_issue = 0;
    logic [AW-1:0] last_issue;

    // fetch reference model
    logic [AW-1:0] m_fpc;
    bit            m_busy, m_drop, m_halt;
    ent_t          mq[$];

    bit            e_req, e_ov;
    logic [AW-1:0] e_addr, e_opc;
    logic [IW-1:0] e_o;

    ifetch #(.AW(AW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
        .im_rdata(im_rdata), .o(o), .ov(ov), .ordy(ordy), .opc(opc), .pcwe(pcwe),
        .npc(npc), .h(h), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_fpc = '0; m_busy = 0; m_drop = 0; m_halt = 0;
        mem_busy = 0; mem_wait = 0;
        im_ack = 0; im_rdata = '0; ordy = 0; pcwe = 0; npc = '0; h = 0;
    endtask

    // Drive one cycle's inputs and derive this cycle's expected outputs from the model
    task automatic pre(input bit r, input bit pw, input logic [AW-1:0] np, input bit hh);
        ordy = r; pcwe = pw; npc = np; h = hh;
        if (mem_busy && mem_wait == 0) begin
            im_ack = 1; im_rdata = IW'(mem_addr) + 16'h1000;
        end else begin
            im_ack = 0; im_rdata = IW'($urandom);
        end
        e_req  = m_busy || (!m_halt && !pw && (mq.size() + int'(m_busy) < 2));
        e_addr = m_fpc;
        e_ov   = (mq.size() != 0) && !m_halt;
        e_o    = e_ov ? mq[0].w : '0;
        e_opc  = e_ov ? mq[0].a : '0;
        #1;
    endtask

    // Advance model and memory across the clock edge, then align to the next drive point
    task automatic post();
        bit ack, pop, nh;
        ent_t e;
        ack = im_ack && m_busy;
        pop = e_ov && ordy;
        nh  = m_halt || (h && pop);
        if (pcwe) begin
            mq.delete();
            m_fpc  = npc;
            m_drop = m_busy && !ack;
            m_busy = m_busy && !ack;
        end else begin
            if (pop) void'(mq.pop_front());
            if (ack) begin
                if (m_drop) begin
                    m_drop = 0;
                end else if (!m_halt) begin
                    e.a = m_fpc; e.w = 16'h1000 + IW'(m_fpc);
                    mq.push_back(e);
                    m_fpc = m_fpc + 1'b1;
                end
                m_busy = 0;
            end else if (e_req && !m_busy) begin
                m_busy = 1;
            end
        end
        m_halt = nh;
        if (im_ack) begin
            mem_busy = 0;
        end else if (mem_busy) begin
            mem_wait--;
        end else if (im_req) begin
            mem_busy = 1; mem_addr = im_addr; mem_wait = $urandom_range(lat_max, lat_min) - 1;
            n_issue++; last_issue = im_addr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1;
        model_reset();
        #1;
        n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL reset_im_req: got %b expected 0", im_req); end
        n_checks++; if (im_addr !== '0) begin n_fail++; $display("FAIL reset_im_addr: got %h expected 00", im_addr); end
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b expected 0", ov); end
        n_checks++; if (o !== '0) begin n_fail++; $display("FAIL reset_o: got %h expected 0000", o); end
        n_checks++; if (opc !== '0) begin n_fail++; $display("FAIL reset_opc: got %h expected 00", opc); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        lat_min = 3; lat_max = 3;
        do_reset();
        pre(1, 0, '0, 0);
        n_checks++;
        if (im_req !== 1'b1 || im_addr !== 8'h00) begin
            n_fail++; $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=00", im_req, im_addr);
        end
        post();
        pre(1, 0, '0, 0); post();
        do_reset();
        pre(1, 0, '0, 0);
        n_checks++;
        if (im_req !== 1'b1 || im_addr !== 8'h00) begin
            n_fail++; $display("FAIL reset_abandon: got req=%b addr=%h expected req=1 addr=00", im_req, im_addr);
        end
        post();
    endtask

    task automatic test_stream();
        int k = 0;
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            pre(1, 0, '0, 0);
            n_checks++;
            if (im_req !== e_req || im_addr !== e_addr || ov !== e_ov || o !== e_o || opc !== e_opc) begin
                n_fail++;
                $display("FAIL stream_model: got req=%b addr=%h ov=%b o=%h opc=%h expected req=%b addr=%h ov=%b o=%h opc=%h",
                         im_req, im_addr, ov, o, opc, e_req, e_addr, e_ov, e_o, e_opc);
            end
            if (ov === 1'b1) begin
                n_checks++;
                if (o !== 16'h1000 + IW'(k) || opc !== AW'(k)) begin
                    n_fail++; $display("FAIL stream_seq: got o=%h opc=%h expected o=%h opc=%h", o, opc, 16'h1000 + IW'(k), AW'(k));
                end
                k++;
            end
            post();
        end
        n_checks++;
        if (k < 5) begin n_fail++; $display("FAIL stream_rate: got %0d instructions expected at least 5", k); end
    endtask

    task automatic test_stall();
        logic [IW-1:0] held = '0;
        lat_min = 1; lat_max = 1;
        for (int c = 0; c < 10; c++) begin
            pre(0, 0, '0, 0);
            if (c == 5) held = e_o;
            n_checks++;
            if (im_req !== e_req || ov !== e_ov || o !== e_o || opc !== e_opc) begin
                n_fail++;
                $display("FAIL stall_model: got req=%b ov=%b o=%h opc=%h expected req=%b ov=%b o=%h opc=%h",
                         im_req, ov, o, opc, e_req, e_ov, e_o, e_opc);
            end
            if (c >= 6) begin
                n_checks++;
                if (im_req !== 1'b0 || ov !== 1'b1 || o !== held || mq.size() != 2) begin
                    n_fail++; $display("FAIL stall_hold: got req=%b ov=%b o=%h expected req=0 ov=1 o=%h", im_req, ov, o, held);
                end
            end
            post();
        end
        for (int c = 0; c < 8; c++) begin
            pre(1, 0, '0, 0);
            if (c == 0) begin
                n_checks++;
                if (ov !== 1'b1 || o !== held) begin n_fail++; $display("FAIL stall_resume: got ov=%b o=%h expected ov=1 o=%h", ov, o, held); end
            end
            n_checks++;
            if (im_req !== e_req || im_addr !== e_addr || ov !== e_ov || o !== e_o || opc !== e_opc) begin
                n_fail++;
                $display("FAIL stall_drain: got req=%b addr=%h ov=%b o=%h opc=%h expected req=%b addr=%h ov=%b o=%h opc=%h",
                         im_req, im_addr, ov, o, opc, e_req, e_addr, e_ov, e_o, e_opc);
            end
            post();
        end
    endtask

    task automatic test_redirect();
        int  n0;
        bit  first = 1;
        bit  chk_issue = 1;
        lat_min = 3; lat_max = 3;
        pre(1, 1, 8'h05, 0); post();
        for (int c = 0; c < 12 && !(mem_busy && mem_addr == 8'h05); c++) begin
            pre(1, 0, '0, 0); post();
        end
        n_checks++;
        if (!(mem_busy && mem_addr == 8'h05)) begin n_fail++; $display("FAIL redir_setup: got no request to 05 expected one outstanding"); end
        n0 = n_issue;
        pre(1, 1, 8'h40, 0);
        n_checks++;
        if (im_req !== e_req) begin n_fail++; $display("FAIL redir_hold: got req=%b expected %b", im_req, e_req); end
        post();
        lat_min = 1; lat_max = 1;
        for (int c = 0; c < 16; c++) begin
            pre(1, 0, '0, 0);
            n_checks++;
            if (ov === 1'b1 && o === 16'h1005) begin n_fail++; $display("FAIL redir_stale: got o=%h expected not 1005", o); end
            if (ov === 1'b1 && first) begin
                first = 0;
                n_checks++;
                if (opc !== 8'h40 || o !== 16'h1040) begin n_fail++; $display("FAIL redir_first: got opc=%h o=%h expected opc=40 o=1040", opc, o); end
            end
            post();
            if (chk_issue && n_issue == n0 + 1) begin
                chk_issue = 0;
                n_checks++;
                if (last_issue !== 8'h40) begin n_fail++; $display("FAIL redir_addr: got %h expected 40", last_issue); end
            end
        end
        n_checks++;
        if (first || chk_issue) begin n_fail++; $display("FAIL redir_timeout: got no output after redirect expected opc 40"); end
    endtask

    task automatic test_ack_pop();
        lat_min = 1; lat_max = 1;
        for (int c = 0; c < 20 && !(mem_busy && mem_wait == 0 && mq.size() == 1); c++) begin
            pre(0, 0, '0, 0); post();
        end
        pre(1, 1, 8'h80, 0);
        n_checks++;
        if (im_ack !== 1'b1 || ov !== 1'b1 || im_req !== e_req) begin
            n_fail++; $display("FAIL ackpop_setup: got ack=%b ov=%b req=%b expected ack=1 ov=1 req=%b", im_ack, ov, im_req, e_req);
        end
        post();
        pre(1, 0, '0, 0);
        n_checks++;
        if (ov !== 1'b0 || im_req !== 1'b1 || im_addr !== 8'h80) begin
            n_fail++; $display("FAIL ackpop_flush: got ov=%b req=%b addr=%h expected ov=0 req=1 addr=80", ov, im_req, im_addr);
        end
        post();
    endtask

    task automatic test_wrap();
        logic [AW-1:0] wexp [4];
        int k = 0;
        wexp[0] = 8'hFE; wexp[1] = 8'hFF; wexp[2] = 8'h00; wexp[3] = 8'h01;
        lat_min = 1; lat_max = 1;
        pre(1, 1, 8'hFE, 0); post();
        for (int c = 0; c < 14; c++) begin
            pre(1, 0, '0, 0);
            if (ov === 1'b1 && k < 4) begin
                n_checks++;
                if (opc !== wexp[k] || o !== 16'h1000 + IW'(wexp[k])) begin
                    n_fail++; $display("FAIL wrap_seq: got opc=%h o=%h expected opc=%h o=%h", opc, o, wexp[k], 16'h1000 + IW'(wexp[k]));
                end
                k++;
            end
            post();
        end
        n_checks++;
        if (k != 4) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", k); end
    endtask

    task automatic test_halt();
        bit hh;
        lat_min = 1; lat_max = 1;
        pre(1, 1, 8'h05, 0); post();
        for (int c = 0; c < 30 && !m_halt; c++) begin
            hh = (mq.size() > 0) && (mq[0].a == 8'h07);
            pre(1, hh, 8'h20, hh);
            n_checks++;
            if (ov !== e_ov || o !== e_o || opc !== e_opc || halted !== 1'b0) begin
                n_fail++; $display("FAIL halt_run: got ov=%b o=%h opc=%h halted=%b expected ov=%b o=%h opc=%h halted=0",
                                   ov, o, opc, halted, e_ov, e_o, e_opc);
            end
            post();
        end
        for (int c = 0; c < 6; c++) begin
            pre(1, 0, '0, 0);
            n_checks++;
            if (halted !== 1'b1 || ov !== 1'b0 || o !== '0 || opc !== '0 || im_addr !== 8'h20) begin
                n_fail++; $display("FAIL halt_state: got halted=%b ov=%b o=%h opc=%h addr=%h expected halted=1 ov=0 o=0000 opc=00 addr=20",
                                   halted, ov, o, opc, im_addr);
            end
            if (c >= 2) begin
                n_checks++;
                if (im_req !== 1'b0) begin n_fail++; $display("FAIL halt_req: got %b expected 0", im_req); end
            end
            post();
        end
        do_reset();
        pre(1, 0, '0, 0);
        n_checks++;
        if (im_req !== 1'b1 || im_addr !== 8'h00 || halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_restart: got req=%b addr=%h halted=%b expected req=1 addr=00 halted=0", im_req, im_addr, halted);
        end
        post();
    endtask

    task automatic test_random();
        bit r, pw, hh;
        logic [AW-1:0] np;
        lat_min = 1; lat_max = 3;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r  = ($urandom_range(0, 3) != 0);
            pw = ($urandom_range(0, 9) == 0);
            np = AW'($urandom);
            hh = ($urandom_range(0, 49) == 0);
            pre(r, pw, np, hh);
            n_checks++;
            if (im_req !== e_req || im_addr !== e_addr) begin
                n_fail++; $display("FAIL rand_req: got req=%b addr=%h expected req=%b addr=%h", im_req, im_addr, e_req, e_addr);
            end
            n_checks++;
            if (ov !== e_ov || o !== e_o || opc !== e_opc) begin
                n_fail++; $display("FAIL rand_out: got ov=%b o=%h opc=%h expected ov=%b o=%h opc=%h", ov, o, opc, e_ov, e_o, e_opc);
            end
            n_checks++;
            if (halted !== m_halt) begin n_fail++; $display("FAIL rand_halted: got %b expected %b", halted, m_halt); end
            post();
            if (m_halt && $urandom_range(0, 7) == 0) do_reset();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_ack_pop();
        test_wrap();
        test_halt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
